// File: rtl/io_port_bridge.sv
// External-side endpoint of the processor IN/OUT port interface: RX FIFO feeding in_port_data,
// TX FIFO draining OUT writes over valid/ready, and an RX-pending interrupt request FSM.
module io_port_bridge #(
    parameter int DATA_W   = 16,
    parameter int RX_DEPTH = 4,
    parameter int TX_DEPTH = 4,
    parameter bit INT_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] out_port_data,
    input  logic              port_wr,
    output logic [DATA_W-1:0] in_port_data,
    input  logic              port_rd,
    output logic              int_req,
    input  logic              int_ack,
    output logic              tx_full,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    output logic [1:0]        err_flags
);

    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [RX_AW:0]   RX_FULL    = (RX_AW + 1)'(RX_DEPTH);
    localparam logic [TX_AW:0]   TX_FULL    = (TX_AW + 1)'(TX_DEPTH);
    localparam logic [RX_AW-1:0] RX_PTR_ONE = RX_AW'(1);
    localparam logic [TX_AW-1:0] TX_PTR_ONE = TX_AW'(1);
    localparam logic [RX_AW:0]   RX_CNT_ONE = (RX_AW + 1)'(1);
    localparam logic [TX_AW:0]   TX_CNT_ONE = (TX_AW + 1)'(1);

    typedef enum logic [1:0] {
        INT_IDLE    = 2'd0,
        INT_REQ     = 2'd1,
        INT_SERVICE = 2'd2
    } int_state_t;

    logic [DATA_W-1:0] r_rxMem [RX_DEPTH];
    logic [RX_AW-1:0]  r_rxWp;
    logic [RX_AW-1:0]  r_rxRp;
    logic [RX_AW:0]    r_rxCount;
    logic [DATA_W-1:0] r_txMem [TX_DEPTH];
    logic [TX_AW-1:0]  r_txWp;
    logic [TX_AW-1:0]  r_txRp;
    logic [TX_AW:0]    r_txCount;
    logic [1:0]        r_errFlags;
    int_state_t        r_intState;
    int_state_t        w_intNext;
    logic              r_intReq;

    logic w_rxEmpty, w_txEmpty;
    logic w_rxPush, w_rxPop, w_txPush, w_txPop;

    assign w_rxEmpty     = (r_rxCount == '0);
    assign w_txEmpty     = (r_txCount == '0);
    assign ext_in_ready  = (r_rxCount != RX_FULL);
    assign tx_full       = (r_txCount == TX_FULL);
    assign ext_out_valid = !w_txEmpty;
    assign w_rxPush      = ext_in_valid && ext_in_ready;
    assign w_rxPop       = port_rd && !w_rxEmpty;
    assign w_txPush      = port_wr && !tx_full;
    assign w_txPop       = ext_out_valid && ext_out_ready;

    assign in_port_data  = w_rxEmpty ? '0 : r_rxMem[r_rxRp];
    assign ext_out_data  = w_txEmpty ? '0 : r_txMem[r_txRp];
    assign err_flags     = r_errFlags;
    assign int_req       = r_intReq;

    // Storage is never reset; stale words are masked by the counts.
    always_ff @(posedge clk) begin
        if (w_rxPush) r_rxMem[r_rxWp] <= ext_in_data;
        if (w_txPush) r_txMem[r_txWp] <= out_port_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxWp     <= '0;
            r_rxRp     <= '0;
            r_rxCount  <= '0;
            r_txWp     <= '0;
            r_txRp     <= '0;
            r_txCount  <= '0;
            r_errFlags <= '0;
        end else begin
            if (w_rxPush) r_rxWp <= r_rxWp + RX_PTR_ONE;
            if (w_rxPop)  r_rxRp <= r_rxRp + RX_PTR_ONE;
            if (w_rxPush && !w_rxPop)      r_rxCount <= r_rxCount + RX_CNT_ONE;
            else if (!w_rxPush && w_rxPop) r_rxCount <= r_rxCount - RX_CNT_ONE;

            if (w_txPush) r_txWp <= r_txWp + TX_PTR_ONE;
            if (w_txPop)  r_txRp <= r_txRp + TX_PTR_ONE;
            if (w_txPush && !w_txPop)      r_txCount <= r_txCount + TX_CNT_ONE;
            else if (!w_txPush && w_txPop) r_txCount <= r_txCount - TX_CNT_ONE;

            // Overflow is judged on the registered count, so a same-cycle pop cannot rescue the word.
            r_errFlags <= r_errFlags | {port_wr && tx_full, port_rd && w_rxEmpty};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_intState <= INT_IDLE;
            r_intReq   <= 1'b0;
        end else begin
            r_intState <= w_intNext;
            r_intReq   <= (w_intNext == INT_REQ);
        end
    end

    // Request is level-held until acknowledged; a new request needs the FIFO to drain first.
    always_comb begin
        w_intNext = r_intState;
        case (r_intState)
            INT_IDLE:    if (!w_rxEmpty) w_intNext = INT_REQ;
            INT_REQ:     if (int_ack)    w_intNext = INT_SERVICE;
            INT_SERVICE: if (w_rxEmpty)  w_intNext = INT_IDLE;
            default:                     w_intNext = INT_IDLE;
        endcase
        if (!INT_EN) w_intNext = INT_IDLE;
    end

endmodule

// File: doc/io_port_bridge.md
Name: io_port_bridge

Overview:
External-side endpoint of the processor's IN/OUT port interface.
- Buffers words arriving from the outside world into an RX FIFO and presents them on the processor's in_port_data; an IN instruction (READ_PORT) pops the FIFO.
- Captures OUT-instruction writes (WRITE_PORT with out_port_data) into a TX FIFO and drains them to the outside over a valid/ready handshake.
- Raises an interrupt request toward the processor's interrupt input while RX data is pending.

Parameters:
DATA_W, 16, port word width
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
INT_EN, 1, 1 = interrupt FSM active; 0 = int_req held 0

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
out_port_data  in  DATA_W  word written by OUT instruction
port_wr  in  1  WRITE_PORT strobe from the processor, one cycle per OUT
in_port_data  out  DATA_W  RX FIFO head word to the processor
port_rd  in  1  READ_PORT strobe from the processor, one cycle per IN
int_req  out  1  interrupt request to the processor
int_ack  in  1  processor interrupt acknowledge, 1-cycle pulse
tx_full  out  1  TX FIFO full; software/HDU must not issue OUT
ext_in_data  in  DATA_W  external input word
ext_in_valid  in  1  external word valid
ext_in_ready  out  1  RX FIFO can accept a word
ext_out_data  out  DATA_W  TX FIFO head word
ext_out_valid  out  1  TX FIFO non-empty
ext_out_ready  in  1  external sink accepts the word
err_flags  out  2  sticky: [0] RX underflow (port_rd while empty), [1] TX overflow (port_wr while full)

Behaviour:
- Reset (asynchronous, any time, including mid-transfer): both FIFOs empty, pointers and counts 0, FSM to INT_IDLE.
  - Outputs during reset: int_req=0, err_flags=0, in_port_data=0, ext_out_data=0, ext_out_valid=0, tx_full=0, ext_in_ready=1.
  - Words held in either FIFO are discarded.
- RX FIFO:
  - Push when ext_in_valid && ext_in_ready.
  - ext_in_ready = (rx_count != RX_DEPTH), combinational from registered count.
  - in_port_data = head word when non-empty, else 0x0000. Combinational from FIFO registers, so the word is valid in the same cycle as port_rd.
  - port_rd pops when non-empty. port_rd while empty: no pointer change, err_flags[0] set.
  - Full with simultaneous pop: ready is 0, so no push that cycle; count drops by 1.
  - Non-full with simultaneous push and pop: count unchanged, both pointers advance.
- TX FIFO:
  - Push on port_wr when not full.
  - port_wr while full: word dropped, err_flags[1] set. A pop in the same cycle does not rescue it; full is evaluated on the registered count.
  - ext_out_valid = non-empty; ext_out_data = head, or 0 when empty.
  - Pop when ext_out_valid && ext_out_ready.
  - Simultaneous push and pop when non-full: count unchanged.
  - tx_full = (tx_count == TX_DEPTH).
  - ext_out_data stays stable while ext_out_valid && !ext_out_ready.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Counts: log2(DEPTH)+1 bits.
- err_flags: sticky until reset.
- Interrupt FSM (int_req is a registered output):
  - INT_IDLE: int_req=0. Go to INT_REQ when rx_count != 0 (registered), so int_req rises 1 cycle after the first word lands.
  - INT_REQ: int_req=1. On int_ack go to INT_SERVICE; int_req drops the next cycle.
  - INT_SERVICE: int_req=0. Go to INT_IDLE when rx_count == 0. A re-request therefore needs an empty-then-refill cycle.
  - int_ack outside INT_REQ is ignored.
  - If the RX FIFO empties via port_rd while in INT_REQ, stay in INT_REQ until int_ack (the request is level-held).
  - INT_EN=0: FSM forced to INT_IDLE, int_req=0.
- Latencies:
  - External word to in_port_data: 1 cycle after the push edge.
  - port_wr to ext_out_valid: 1 cycle.

Test Plan:
1. Reset, then push ext 0x1111, 0x2222. Expect in_port_data=0x1111 the cycle after the first push. port_rd → 0x2222 next, then 0x0000 after a second port_rd; err_flags stays 00.
2. Push 5 words 0xA000..0xA004 with RX_DEPTH=4 and no reads. Expect ext_in_ready=0 after the 4th word; the 5th is held by the source. One port_rd re-raises ready, and 0xA004 is accepted the next cycle.
3. Five port_wr (0xB000..0xB004) with ext_out_ready=0. Expect tx_full=1 after 4 words, the 5th word dropped, err_flags[1]=1. Raise ready: ext_out_data sequence 0xB000..0xB003, then ext_out_valid=0.
4. Push 0x0042 ext. Expect int_req=1 two edges later. Pulse int_ack → int_req=0 and FSM in INT_SERVICE; port_rd empties the FIFO → INT_IDLE. Push 0x0043 → int_req reasserts.
5. port_rd on empty FIFO → err_flags[0]=1 and in_port_data=0x0000; the flag persists until reset.
6. Assert reset mid-stream with RX=2 words, TX=3 words, int_req=1. Expect all outputs at reset values immediately (asynchronous); after release, in_port_data=0 and ext_out_valid=0.
